// File: rtl/cpu_bus_arbiter_if.sv
// Bundles the CPU ibus/dbus ports and the shared downstream bus of cpu_bus_arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface cpu_bus_arbiter_if;
  logic        i_ibus_request;
  logic        o_ibus_ready;
  logic [31:0] i_ibus_address;
  logic [31:0] o_ibus_rdata;

  logic        i_dbus_rw;
  logic        i_dbus_request;
  logic        o_dbus_ready;
  logic [31:0] i_dbus_address;
  logic [31:0] i_dbus_wdata;
  logic [31:0] o_dbus_rdata;

  logic        o_bus_rw;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_bus_wdata;

  logic        o_fault;

  modport slave (
    input  i_ibus_request, i_ibus_address,
    input  i_dbus_rw, i_dbus_request, i_dbus_address, i_dbus_wdata,
    input  i_bus_ready, i_bus_rdata,
    output o_ibus_ready, o_ibus_rdata,
    output o_dbus_ready, o_dbus_rdata,
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    output o_fault
  );

  modport master (
    output i_ibus_request, i_ibus_address,
    output i_dbus_rw, i_dbus_request, i_dbus_address, i_dbus_wdata,
    output i_bus_ready, i_bus_rdata,
    input  o_ibus_ready, o_ibus_rdata,
    input  o_dbus_ready, o_dbus_rdata,
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    input  o_fault
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares one downstream memory bus between the CPU instruction and data buses.
// Registered grant FSM with fixed-priority or round-robin tie-break and a stall watchdog.
module cpu_bus_arbiter #(
  parameter bit          DBUS_PRIORITY = 1'b1,
  parameter int unsigned TIMEOUT       = 0
) (
  input logic              i_clock,
  input logic              i_reset,
  cpu_bus_arbiter_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RELEASE_I, RELEASE_D} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_lastGrantD;
  logic [CW-1:0]   r_wdogCount;
  logic            r_fault;
  logic            w_granted;

  assign w_granted = (r_state == GRANT_I) || (r_state == GRANT_D);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    bus.o_bus_request  = 1'b0;
    bus.o_bus_rw       = 1'b0;
    bus.o_bus_address  = bus.i_ibus_address;
    bus.o_bus_wdata    = '0;
    bus.o_ibus_ready   = 1'b0;
    bus.o_dbus_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_ibus_request && bus.i_dbus_request) begin
          if (DBUS_PRIORITY || !r_lastGrantD) w_next = GRANT_D;
          else                                w_next = GRANT_I;
        end else if (bus.i_dbus_request) begin
          w_next = GRANT_D;
        end else if (bus.i_ibus_request) begin
          w_next = GRANT_I;
        end
      end
      GRANT_I: begin
        bus.o_bus_request = 1'b1;
        bus.o_ibus_ready  = bus.i_bus_ready;
        if (bus.i_bus_ready) w_next = RELEASE_I;
      end
      GRANT_D: begin
        bus.o_bus_request = 1'b1;
        bus.o_bus_rw      = bus.i_dbus_rw;
        bus.o_bus_address = bus.i_dbus_address;
        bus.o_bus_wdata   = bus.i_dbus_wdata;
        bus.o_dbus_ready  = bus.i_bus_ready;
        if (bus.i_bus_ready) w_next = RELEASE_D;
      end
      // Hold off until the served requester drops, so a stale request is not re-issued
      RELEASE_I: if (!bus.i_ibus_request) w_next = IDLE;
      RELEASE_D: if (!bus.i_dbus_request) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lastGrantD <= 1'b0;
      r_wdogCount  <= '0;
      r_fault      <= 1'b0;
    end else begin
      if (w_granted && bus.i_bus_ready) r_lastGrantD <= (r_state == GRANT_D);
      if (r_state == IDLE && w_next != IDLE) begin
        r_wdogCount <= '0;
      end else if ((TIMEOUT > 0) && w_granted && !bus.i_bus_ready && (r_wdogCount != TMAX)) begin
        r_wdogCount <= r_wdogCount + CW'(1);
        if (r_wdogCount == TLAST) r_fault <= 1'b1;
      end
    end
  end

  assign bus.o_fault      = r_fault;
  assign bus.o_ibus_rdata = bus.i_bus_rdata;
  assign bus.o_dbus_rdata = bus.i_bus_rdata;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: dutA (dbus priority, TIMEOUT=8) and dutB (round-robin).
// Expected downstream transactions are queued when requests are driven and popped at each grant.
module tb_cpu_bus_arbiter;

  typedef struct {
    logic        isData;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared = 0;
  int   nMismatched = 0;
  txn_t expQ[$];

  cpu_bus_arbiter_if busA ();
  cpu_bus_arbiter_if busB ();

  cpu_bus_arbiter #(.DBUS_PRIORITY(1'b1), .TIMEOUT(8)) dutA (
    .i_clock(clk), .i_reset(rst), .bus(busA.slave)
  );
  cpu_bus_arbiter #(.DBUS_PRIORITY(1'b0), .TIMEOUT(0)) dutB (
    .i_clock(clk), .i_reset(rst), .bus(busB.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrantA(input int budget, output bit ok);
    int n = 0;
    while (!busA.o_bus_request && n < budget) begin
      tick();
      n++;
    end
    ok = busA.o_bus_request;
  endtask

  // Memory model: ready pulse after 'latency' cycles of grant, readies sampled mid-cycle
  task automatic memRespond(input int latency, input logic [31:0] data,
                            output logic iRdy, output logic dRdy, output logic [31:0] rdOut);
    repeat (latency) tick();
    busA.i_bus_ready = 1'b1;
    busA.i_bus_rdata = data;
    #1;
    iRdy  = busA.o_ibus_ready;
    dRdy  = busA.o_dbus_ready;
    rdOut = iRdy ? busA.o_ibus_rdata : busA.o_dbus_rdata;
    tick();
    busA.i_bus_ready = 1'b0;
    busA.i_bus_rdata = '0;
  endtask

  task automatic test_reset();
    #1;
    nCompared += 5;
    if (busA.o_bus_request !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_reqA got %b want 0", busA.o_bus_request); end
    if (busA.o_ibus_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_irdyA got %b want 0", busA.o_ibus_ready); end
    if (busA.o_dbus_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_drdyA got %b want 0", busA.o_dbus_ready); end
    if (busA.o_fault !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_faultA got %b want 0", busA.o_fault); end
    if (busB.o_bus_request !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_reqB got %b want 0", busB.o_bus_request); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ibus_read();
    txn_t e;
    bit ok;
    logic iRdy, dRdy;
    logic [31:0] rd;
    busA.i_ibus_address = 32'h100;
    busA.i_ibus_request = 1'b1;
    expQ.push_back('{isData: 1'b0, rw: 1'b0, addr: 32'h100, wdata: 32'h0});
    #1;
    nCompared++;
    if (busA.o_bus_request !== 1'b0) begin nMismatched++; $display("[TB] FAIL ird_early_req got %b want 0", busA.o_bus_request); end
    tick();
    nCompared++;
    if (busA.o_bus_request !== 1'b1) begin nMismatched++; $display("[TB] FAIL ird_latency got %b want 1", busA.o_bus_request); end
    waitGrantA(4, ok);
    e = expQ.pop_front();
    nCompared += 3;
    if (busA.o_bus_address !== e.addr) begin nMismatched++; $display("[TB] FAIL ird_addr got %h want %h", busA.o_bus_address, e.addr); end
    if (busA.o_bus_rw !== e.rw) begin nMismatched++; $display("[TB] FAIL ird_rw got %b want %b", busA.o_bus_rw, e.rw); end
    if (busA.o_bus_wdata !== e.wdata) begin nMismatched++; $display("[TB] FAIL ird_wdata got %h want %h", busA.o_bus_wdata, e.wdata); end
    memRespond(3, 32'hDEADBEEF, iRdy, dRdy, rd);
    nCompared += 3;
    if (iRdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL ird_irdy got %b want 1", iRdy); end
    if (dRdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL ird_drdy got %b want 0", dRdy); end
    if (rd !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL ird_rdata got %h want deadbeef", rd); end
    busA.i_ibus_request = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    txn_t e;
    bit ok;
    logic iRdy, dRdy;
    logic [31:0] rd;
    busA.i_ibus_address = 32'h200;
    busA.i_dbus_address = 32'h1000;
    busA.i_dbus_wdata   = 32'h55;
    busA.i_dbus_rw      = 1'b1;
    busA.i_ibus_request = 1'b1;
    busA.i_dbus_request = 1'b1;
    expQ.push_back('{isData: 1'b1, rw: 1'b1, addr: 32'h1000, wdata: 32'h55});
    expQ.push_back('{isData: 1'b0, rw: 1'b0, addr: 32'h200, wdata: 32'h0});
    for (int k = 0; k < 2; k++) begin
      waitGrantA(6, ok);
      e = expQ.pop_front();
      nCompared += 6;
      if (!ok) begin nMismatched++; $display("[TB] FAIL pri_grant%0d got no grant want grant", k); end
      if (busA.o_bus_address !== e.addr) begin nMismatched++; $display("[TB] FAIL pri_addr%0d got %h want %h", k, busA.o_bus_address, e.addr); end
      if (busA.o_bus_rw !== e.rw) begin nMismatched++; $display("[TB] FAIL pri_rw%0d got %b want %b", k, busA.o_bus_rw, e.rw); end
      if (busA.o_bus_wdata !== e.wdata) begin nMismatched++; $display("[TB] FAIL pri_wdata%0d got %h want %h", k, busA.o_bus_wdata, e.wdata); end
      memRespond(2, 32'hCAFE0000 + k, iRdy, dRdy, rd);
      if (dRdy !== e.isData) begin nMismatched++; $display("[TB] FAIL pri_drdy%0d got %b want %b", k, dRdy, e.isData); end
      if (iRdy !== !e.isData) begin nMismatched++; $display("[TB] FAIL pri_irdy%0d got %b want %b", k, iRdy, !e.isData); end
      if (e.isData) busA.i_dbus_request = 1'b0;
      else          busA.i_ibus_request = 1'b0;
    end
    busA.i_dbus_rw = 1'b0;
    tick();
  endtask

  task automatic test_hold_after_ready();
    bit ok;
    logic iRdy, dRdy;
    logic [31:0] rd;
    busA.i_ibus_address = 32'h300;
    busA.i_ibus_request = 1'b1;
    waitGrantA(4, ok);
    memRespond(1, 32'h0BADF00D, iRdy, dRdy, rd);
    nCompared++;
    if (iRdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_irdy got %b want 1", iRdy); end
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (busA.o_bus_request !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_noreissue%0d got %b want 0", k, busA.o_bus_request); end
      tick();
    end
    busA.i_ibus_request = 1'b0;
    tick();
    tick();
    nCompared++;
    if (busA.o_bus_request !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_idle got %b want 0", busA.o_bus_request); end
  endtask

  task automatic test_timeout();
    bit ok;
    busA.i_dbus_address = 32'h400;
    busA.i_dbus_rw      = 1'b0;
    busA.i_dbus_request = 1'b1;
    tick();
    waitGrantA(4, ok);
    repeat (7) tick();
    nCompared++;
    if (busA.o_fault !== 1'b0) begin nMismatched++; $display("[TB] FAIL wdog_early got %b want 0", busA.o_fault); end
    tick();
    nCompared += 2;
    if (busA.o_fault !== 1'b1) begin nMismatched++; $display("[TB] FAIL wdog_fault got %b want 1", busA.o_fault); end
    if (busA.o_bus_request !== 1'b1) begin nMismatched++; $display("[TB] FAIL wdog_staygrant got %b want 1", busA.o_bus_request); end
    repeat (3) tick();
    nCompared++;
    if (busA.o_fault !== 1'b1) begin nMismatched++; $display("[TB] FAIL wdog_sticky got %b want 1", busA.o_fault); end
    rst = 1'b1;
    #1;
    nCompared += 2;
    if (busA.o_fault !== 1'b0) begin nMismatched++; $display("[TB] FAIL wdog_rstfault got %b want 0", busA.o_fault); end
    if (busA.o_bus_request !== 1'b0) begin nMismatched++; $display("[TB] FAIL wdog_rstreq got %b want 0", busA.o_bus_request); end
    busA.i_dbus_request = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bit ok;
    logic iRdy, dRdy;
    logic [31:0] rd;
    busA.i_dbus_address = 32'h600;
    busA.i_dbus_request = 1'b1;
    waitGrantA(4, ok);
    busA.i_bus_ready = 1'b1;
    #1;
    nCompared++;
    if (busA.o_dbus_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_drdy_pre got %b want 1", busA.o_dbus_ready); end
    #1;
    rst = 1'b1;
    #1;
    nCompared += 2;
    if (busA.o_dbus_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_drdy got %b want 0", busA.o_dbus_ready); end
    if (busA.o_bus_request !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_req got %b want 0", busA.o_bus_request); end
    busA.i_bus_ready    = 1'b0;
    busA.i_dbus_request = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    busA.i_ibus_address = 32'h500;
    busA.i_ibus_request = 1'b1;
    expQ.push_back('{isData: 1'b0, rw: 1'b0, addr: 32'h500, wdata: 32'h0});
    waitGrantA(4, ok);
    begin
      txn_t e;
      e = expQ.pop_front();
      nCompared += 2;
      if (!ok) begin nMismatched++; $display("[TB] FAIL rmid_fresh_grant got none want grant"); end
      if (busA.o_bus_address !== e.addr) begin nMismatched++; $display("[TB] FAIL rmid_fresh_addr got %h want %h", busA.o_bus_address, e.addr); end
    end
    memRespond(2, 32'h12345678, iRdy, dRdy, rd);
    nCompared += 2;
    if (iRdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_fresh_irdy got %b want 1", iRdy); end
    if (rd !== 32'h12345678) begin nMismatched++; $display("[TB] FAIL rmid_fresh_rdata got %h want 12345678", rd); end
    busA.i_ibus_request = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    txn_t e;
    int n;
    busB.i_ibus_address = 32'h2000;
    busB.i_dbus_address = 32'h3000;
    busB.i_dbus_rw      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expQ.push_back('{isData: 1'b1, rw: 1'b0, addr: 32'h3000, wdata: 32'h0});
      else            expQ.push_back('{isData: 1'b0, rw: 1'b0, addr: 32'h2000, wdata: 32'h0});
    end
    busB.i_ibus_request = 1'b1;
    busB.i_dbus_request = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!busB.o_bus_request && n < 6) begin tick(); n++; end
      e = expQ.pop_front();
      nCompared += 2;
      if (!busB.o_bus_request) begin nMismatched++; $display("[TB] FAIL rr_grant%0d got none want grant", k); end
      if (busB.o_bus_address !== e.addr) begin nMismatched++; $display("[TB] FAIL rr_order%0d got %h want %h", k, busB.o_bus_address, e.addr); end
      busB.i_bus_ready = 1'b1;
      busB.i_bus_rdata = 32'hA0 + k;
      #1;
      nCompared += 2;
      if (busB.o_dbus_ready !== e.isData) begin nMismatched++; $display("[TB] FAIL rr_drdy%0d got %b want %b", k, busB.o_dbus_ready, e.isData); end
      if (busB.o_ibus_ready !== !e.isData) begin nMismatched++; $display("[TB] FAIL rr_irdy%0d got %b want %b", k, busB.o_ibus_ready, !e.isData); end
      tick();
      busB.i_bus_ready = 1'b0;
      if (e.isData) busB.i_dbus_request = 1'b0;
      else          busB.i_ibus_request = 1'b0;
      tick();
      busB.i_ibus_request = 1'b1;
      busB.i_dbus_request = 1'b1;
    end
    busB.i_ibus_request = 1'b0;
    busB.i_dbus_request = 1'b0;
    tick();
  endtask

  initial begin
    busA.i_ibus_request = 1'b0; busA.i_ibus_address = '0;
    busA.i_dbus_request = 1'b0; busA.i_dbus_address = '0;
    busA.i_dbus_rw = 1'b0; busA.i_dbus_wdata = '0;
    busA.i_bus_ready = 1'b0; busA.i_bus_rdata = '0;
    busB.i_ibus_request = 1'b0; busB.i_ibus_address = '0;
    busB.i_dbus_request = 1'b0; busB.i_dbus_address = '0;
    busB.i_dbus_rw = 1'b0; busB.i_dbus_wdata = '0;
    busB.i_bus_ready = 1'b0; busB.i_bus_rdata = '0;
    test_reset();
    test_ibus_read();
    test_priority();
    test_hold_after_ready();
    test_timeout();
    test_reset_mid_grant();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
